modbus_wr_multi_tx: RTL and testbench

//  Master-side request builder for Modbus RTU function 0x10 (Write Multiple Registers).
//  On a start strobe it reads NUM_REG 16-bit words from the local register bank, indexed 1..NUM_REG.
//  It streams the framed request (header, data, CRC-16) byte-by-byte to the UART transmitter.
//  It is the outbound counterpart of the master's response demux and sits between the register bank and the UART TX.

---
 rtl/modbus_pkg.sv | 23 ++
 rtl/modbus_wr_multi_tx_if.sv | 11 +
 rtl/crc16_modbus_serial.sv | 35 +++
 rtl/modbus_wr_multi_tx.sv | 150 +++++++++++++++
 tb/tb_modbus_wr_multi_tx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/modbus_pkg.sv
// Shared Modbus RTU definitions: function codes, CRC constants and the TX-builder
// state encoding reused by the request builders.
package modbus_pkg;

  localparam logic [7:0]  FC_WRITE_MULTI = 8'h10;
  localparam logic [15:0] CRC_INIT       = 16'hFFFF;
  localparam logic [15:0] CRC_POLY       = 16'hA001;
  localparam int          MAX_WR_REG     = 123;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_SEND,
    ST_GAP
  } tx_state_e;

  // One reflected CRC-16/MODBUS bit-step.
  function automatic logic [15:0] crc16_step(input logic [15:0] c);
    return c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
  endfunction

endpackage

// File: rtl/modbus_wr_multi_tx_if.sv
// Register-bank read port and UART TX byte stream of the fn 0x10 request builder.
interface modbus_wr_multi_tx_if;
  logic [7:0]  reg_idx;
  logic [15:0] reg_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output reg_idx, tx_data, tx_valid, input reg_data, tx_ready);
  modport slave  (input reg_idx, tx_data, tx_valid, output reg_data, tx_ready);
endinterface

// File: rtl/crc16_modbus_serial.sv
// Bit-serial CRC-16/MODBUS: the strobe folds the byte and does the first bit-step,
// the remaining seven steps follow on consecutive clocks while crc_busy is high.
module crc16_modbus_serial
  import modbus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic [7:0]  byte_in,
  input  logic        byte_strb,
  output logic [15:0] crc_out,
  output logic        crc_busy
);

  logic [2:0] step_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_out  <= CRC_INIT;
      step_cnt <= 3'd0;
    end else if (init) begin
      crc_out  <= CRC_INIT;
      step_cnt <= 3'd0;
    end else if (byte_strb) begin
      crc_out  <= crc16_step(crc_out ^ {8'h00, byte_in});
      step_cnt <= 3'd7;
    end else if (step_cnt != 3'd0) begin
      crc_out  <= crc16_step(crc_out);
      step_cnt <= step_cnt - 3'd1;
    end
  end

  assign crc_busy = (step_cnt != 3'd0);

endmodule

// File: rtl/modbus_wr_multi_tx.sv
// Modbus RTU fn 0x10 request builder: reads NUM_REG words from the register bank
// and streams header, data and CRC bytes to the UART TX, then holds the inter-frame gap.
module modbus_wr_multi_tx
  import modbus_pkg::*;
#(
  parameter logic [7:0]  SLAVE_ID   = 8'd1,
  parameter logic [15:0] START_ADR  = 16'd340,
  parameter logic [7:0]  NUM_REG    = 8'd30,
  parameter int          GAP_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  modbus_wr_multi_tx_if.master  bus,
  output logic                  busy,
  output logic                  done
);

  localparam int          GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [8:0]  DATA_1ST = 9'd7;
  localparam logic [8:0]  CRC_LO   = 9'd7 + {NUM_REG, 1'b0};
  localparam logic [8:0]  CRC_HI   = CRC_LO + 9'd1;
  localparam logic [7:0]  BYTE_CNT = {NUM_REG[6:0], 1'b0};
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  tx_state_e     state;
  logic [8:0]    byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   word_buf;
  logic [7:0]    crc_hi_snap;
  logic [7:0]    reg_idx;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          start_q;

  logic          launch;
  logic          is_crc_byte;
  logic          is_data_hi;
  logic          is_data_lo;
  logic          crc_strb;
  logic [7:0]    cur_byte;
  logic [15:0]   crc_out;
  logic          crc_busy;

  assign launch      = start && !start_q && (state == ST_IDLE);
  assign is_crc_byte = (byte_cnt >= CRC_LO);
  assign is_data_hi  = (byte_cnt >= DATA_1ST) && !is_crc_byte && byte_cnt[0];
  assign is_data_lo  = (byte_cnt >= DATA_1ST) && !is_crc_byte && !byte_cnt[0];
  assign crc_strb    = (state == ST_LOAD) && !is_crc_byte;

  // Hi data bytes come straight from the bank; lo bytes from the word captured with them.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_cnt)
      9'd0:    cur_byte = SLAVE_ID;
      9'd1:    cur_byte = FC_WRITE_MULTI;
      9'd2:    cur_byte = START_ADR[15:8];
      9'd3:    cur_byte = START_ADR[7:0];
      9'd4:    cur_byte = 8'h00;
      9'd5:    cur_byte = NUM_REG;
      9'd6:    cur_byte = BYTE_CNT;
      default: cur_byte = byte_cnt[0] ? bus.reg_data[15:8] : word_buf[7:0];
    endcase
  end

  crc16_modbus_serial u_crc (
    .clk       (clk),
    .reset     (reset),
    .init      (launch),
    .byte_in   (cur_byte),
    .byte_strb (crc_strb),
    .crc_out   (crc_out),
    .crc_busy  (crc_busy)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      byte_cnt    <= 9'd0;
      gap_cnt     <= '0;
      word_buf    <= 16'h0000;
      crc_hi_snap <= 8'h00;
      reg_idx     <= 8'd0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        ST_IDLE: if (launch) begin
          state    <= ST_LOAD;
          byte_cnt <= 9'd0;
          busy     <= 1'b1;
          reg_idx  <= 8'd1;
        end
        ST_LOAD: begin
          if (is_crc_byte) begin
            // CRC is complete here; snapshot the hi half so it is never folded.
            if (byte_cnt == CRC_LO) begin
              tx_data     <= crc_out[7:0];
              crc_hi_snap <= crc_out[15:8];
            end else begin
              tx_data <= crc_hi_snap;
            end
            tx_valid <= 1'b1;
            state    <= ST_SEND;
          end else begin
            if (is_data_hi) word_buf <= bus.reg_data;
            tx_data <= cur_byte;
            state   <= ST_CALC;
          end
        end
        ST_CALC: if (!crc_busy) begin
          tx_valid <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: if (bus.tx_ready) begin
          tx_valid <= 1'b0;
          byte_cnt <= byte_cnt + 9'd1;
          if (is_data_lo && reg_idx != NUM_REG) reg_idx <= reg_idx + 8'd1;
          if (byte_cnt == CRC_HI) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            state <= ST_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            reg_idx <= 8'd0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.reg_idx  = reg_idx;
  assign bus.tx_data  = tx_data;
  assign bus.tx_valid = tx_valid;

endmodule

// File: tb/tb_modbus_wr_multi_tx.sv
// Bench for the fn 0x10 request builder: random bank contents and tx_ready patterns
// checked against a frame model built from the Modbus framing and CRC rules.
module tb_modbus_wr_multi_tx;

  localparam logic [7:0]  SLAVE_ID  = 8'd1;
  localparam logic [15:0] START_ADR = 16'd340;
  localparam logic [7:0]  NUM_REG   = 8'd2;
  localparam int          GAP       = 20;
  localparam int          FLEN      = 9 + 2 * NUM_REG;

  logic clk = 1'b0;
  logic reset, start, busy, done;
  int   cycle = 0;

  modbus_wr_multi_tx_if bus();

  modbus_wr_multi_tx #(
    .SLAVE_ID   (SLAVE_ID),
    .START_ADR  (START_ADR),
    .NUM_REG    (NUM_REG),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  logic        c_init, c_strb, c_busy;
  logic [7:0]  c_byte;
  logic [15:0] c_out;

  crc16_modbus_serial u_crc_unit (
    .clk       (clk),
    .reset     (reset),
    .init      (c_init),
    .byte_in   (c_byte),
    .byte_strb (c_strb),
    .crc_out   (c_out),
    .crc_busy  (c_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [15:0] bank [256];
  logic [7:0]  rxq [$];
  logic [7:0]  expq [$];
  int          done_cnt = 0, last_hs = 0, ready_mode = 0, stall_cnt = 0;
  logic        prev_wait = 1'b0, prev_done = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  function automatic logic [15:0] crc_of(input logic [7:0] b [$]);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {8'h00, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic void build_exp();
    logic [15:0] c;
    expq.delete();
    expq.push_back(SLAVE_ID);
    expq.push_back(8'h10);
    expq.push_back(START_ADR[15:8]);
    expq.push_back(START_ADR[7:0]);
    expq.push_back(8'h00);
    expq.push_back(NUM_REG);
    expq.push_back(8'(2 * NUM_REG));
    for (int i = 1; i <= NUM_REG; i++) begin
      expq.push_back(bank[i][15:8]);
      expq.push_back(bank[i][7:0]);
    end
    c = crc_of(expq);
    expq.push_back(c[7:0]);
    expq.push_back(c[15:8]);
  endfunction

  // Bank read data settles half a clock after reg_idx moves; tx_ready is driven
  // before the monitor so it sees the value the next posedge will sample.
  initial forever begin
    @(negedge clk);
    bus.reg_data = bank[bus.reg_idx];
    case (ready_mode)
      1: bus.tx_ready = ($urandom_range(0, 3) != 0);
      2: if (rxq.size() == 4 && stall_cnt < 50) begin
           bus.tx_ready = 1'b0;
           stall_cnt++;
         end else bus.tx_ready = 1'b1;
      3: bus.tx_ready = (rxq.size() != 7);
      default: bus.tx_ready = 1'b1;
    endcase
    if (!reset) begin
      prev_wait = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("hold_valid", bus.tx_valid, 1);
        chk("hold_data", bus.tx_data, prev_data);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        rxq.push_back(bus.tx_data);
        last_hs = cycle + 1;
      end
      prev_wait = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
      if (prev_done) chk("done_1clk", done, 0);
      if (done) begin
        done_cnt++;
        chk("gap_len", cycle - last_hs, GAP);
      end
      prev_done = done;
    end
  end

  task automatic launch(input bit hold);
    @(negedge clk) start = 1'b1;
    @(negedge clk) if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int  d0 = done_cnt;
    bit  ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, ok, 1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_len"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), rxq[i], expq[i]);
  endtask

  task automatic rand_bank();
    for (int i = 0; i < 256; i++) bank[i] = 16'($urandom);
  endtask

  initial begin
    logic [7:0] cb [$];
    int d0;
    reset = 1'b0; start = 1'b0; bus.tx_ready = 1'b0; bus.reg_data = 16'h0;
    c_init = 1'b0; c_strb = 1'b0; c_byte = 8'h00;
    rand_bank();
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.tx_valid, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_idx", bus.reg_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_crc", c_out, 16'hFFFF);
    reset = 1'b1;

    // CRC unit on the standard read-holding-registers request
    cb = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A};
    @(negedge clk) c_init = 1'b1;
    @(negedge clk) c_init = 1'b0;
    foreach (cb[i]) begin
      c_byte = cb[i]; c_strb = 1'b1;
      @(negedge clk) c_strb = 1'b0;
      for (int k = 0; k < 20 && c_busy; k++) @(negedge clk);
    end
    chk("crc_unit", c_out, 16'hCDC5);
    chk("crc_unit_model", c_out, crc_of(cb));

    // Fixed bank, free-running tx_ready
    bank[1] = 16'h000A; bank[2] = 16'h0102;
    build_exp(); rxq.delete(); d0 = done_cnt; ready_mode = 0;
    launch(0);
    wait_done(2000, "t2");
    check_frame("t2");
    chk("t2_busy", busy, 0);
    chk("t2_ndone", done_cnt - d0, 1);

    // 50-clock stall while byte 5 (0x00) is pending
    rand_bank(); build_exp(); rxq.delete(); stall_cnt = 0; ready_mode = 2;
    launch(0);
    for (int k = 0; k < 500 && stall_cnt < 50; k++) @(negedge clk);
    chk("t3_stall_valid", bus.tx_valid, 1);
    chk("t3_stall_data", bus.tx_data, 8'h00);
    wait_done(2000, "t3");
    check_frame("t3");

    // Second start edge while busy is ignored
    rand_bank(); build_exp(); rxq.delete(); d0 = done_cnt; ready_mode = 0;
    launch(0);
    repeat (30) @(negedge clk);
    chk("t4_busy", busy, 1);
    launch(0);
    wait_done(2000, "t4");
    repeat (60) @(negedge clk);
    chk("t4_ndone", done_cnt - d0, 1);
    chk("t4_busy_end", busy, 0);
    check_frame("t4");

    // Reset while byte 8 is pending aborts the frame
    rand_bank(); rxq.delete(); ready_mode = 3;
    launch(0);
    for (int k = 0; k < 500 && !(rxq.size() == 7 && bus.tx_valid); k++) @(negedge clk);
    chk("t5_at_b8", rxq.size(), 7);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_valid", bus.tx_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_idx", bus.reg_idx, 0);
    reset = 1'b1; ready_mode = 0;
    rand_bank(); build_exp(); rxq.delete();
    launch(0);
    wait_done(2000, "t5");
    check_frame("t5");

    // start held high past frame end: no relaunch until it falls and rises
    rand_bank(); build_exp(); rxq.delete(); d0 = done_cnt;
    launch(1);
    wait_done(2000, "t6");
    repeat (60) @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_ndone", done_cnt - d0, 1);
    check_frame("t6");
    start = 1'b0;
    rand_bank(); build_exp(); rxq.delete();
    launch(0);
    wait_done(2000, "t6b");
    check_frame("t6b");

    // Random banks with random back-pressure
    ready_mode = 1;
    for (int f = 0; f < 4; f++) begin
      rand_bank(); build_exp(); rxq.delete();
      launch(0);
      wait_done(4000, $sformatf("rnd%0d", f));
      check_frame($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
